// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer and the rename stage that feeds it and consumes its retire port.
package rob_pkg;

    localparam int DEFAULT_ROBSIZE = 16;
    localparam int ROB_ID_BITS     = $clog2(DEFAULT_ROBSIZE);

    localparam int INSN_ID_W = 16;
    localparam int PC_W      = 32;
    localparam int AREG_W    = 5;
    localparam int PREG_W    = 6;

    typedef logic [ROB_ID_BITS-1:0] rob_id_t;

    typedef struct packed {
        logic rd_valid;
    } si_t;

    typedef struct packed {
        logic [INSN_ID_W-1:0] id;
        logic [PC_W-1:0]      pc;
        logic [AREG_W-1:0]    rd;
        logic [PREG_W-1:0]    prd;
        si_t                  si;
        logic                 fault;
    } di_t;

    typedef struct packed {
        logic [INSN_ID_W-1:0] id;
        logic [PC_W-1:0]      pc;
        logic [AREG_W-1:0]    rd;
        logic [PREG_W-1:0]    prd;
        logic                 needprf2arf;
        logic                 fault;
    } rob_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } rob_state_e;

endpackage

// File: rtl/rob.sv
// In-order reorder buffer: allocates on enqueue, marks done on write-back, retires oldest done entry.
// Latency: enqueue at edge N, earliest write-back in cycle N+1, earliest retire in cycle N+2.
// Backpressure: di_i_ready drops when full or halted; retire has no ready and must always be taken.
module rob
    import rob_pkg::*;
#(
    parameter int ROBSIZE = DEFAULT_ROBSIZE,
    parameter int IDW     = $clog2(ROBSIZE)
) (
    input  logic             clk,
    input  logic             rstn,
    input  di_t              di_i,
    input  logic             di_i_valid,
    output logic             di_i_ready,
    output logic [IDW-1:0]   alloc_idx_o,
    input  logic             wb_valid_i,
    input  logic [IDW-1:0]   wb_idx_i,
    input  logic             wb_fault_i,
    output rob_entry_t       retire_entry_o,
    output logic             retire_entry_o_valid,
    output logic             fault_o,
    output logic [IDW:0]     count_o
);

    localparam int PW = IDW + 1;

    logic [PW-1:0]      head_q, head_d;
    logic [PW-1:0]      tail_q, tail_d;
    logic [ROBSIZE-1:0] done_q, done_d;
    rob_state_e         state_q, state_d;
    rob_entry_t         entry_q [ROBSIZE];

    logic [IDW-1:0] head_idx;
    logic [IDW-1:0] tail_idx;
    logic [IDW-1:0] wb_off;
    logic           empty;
    logic           full;
    logic           enq;
    logic           wb_hit;
    logic           head_done;
    logic           head_fault;
    rob_entry_t     head_entry;
    rob_entry_t     new_entry;

    assign head_idx   = head_q[IDW-1:0];
    assign tail_idx   = tail_q[IDW-1:0];
    assign empty      = (head_q == tail_q);
    assign full       = (head_idx == tail_idx) && (head_q[IDW] != tail_q[IDW]);
    assign count_o    = tail_q - head_q;

    assign head_entry = entry_q[head_idx];
    assign head_done  = done_q[head_idx];
    assign head_fault = head_entry.fault;

    // Only indices between head and tail are live; anything else is a stray write-back and is dropped.
    assign wb_off     = wb_idx_i - head_idx;
    assign wb_hit     = wb_valid_i && ({1'b0, wb_off} < count_o);

    assign di_i_ready           = !full && (state_q == RUN);
    assign enq                  = di_i_valid && di_i_ready;
    assign alloc_idx_o          = tail_idx;
    assign retire_entry_o_valid = !empty && head_done && !head_fault && (state_q == RUN);
    assign fault_o              = (state_q == HALT);
    // Payload RAM is never cleared, so mask the stale head slot while empty.
    assign retire_entry_o       = empty ? '0 : head_entry;

    assign new_entry = '{
        id:          di_i.id,
        pc:          di_i.pc,
        rd:          di_i.rd,
        prd:         di_i.prd,
        needprf2arf: di_i.si.rd_valid,
        fault:       di_i.fault
    };

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        done_d  = done_q;
        state_d = state_q;

        if (wb_hit) begin
            done_d[wb_idx_i] = 1'b1;
        end
        // A fault at rename never executes, so it is complete on arrival.
        if (enq) begin
            done_d[tail_idx] = di_i.fault;
            tail_d           = tail_q + PW'(1);
        end
        if (retire_entry_o_valid) begin
            head_d = head_q + PW'(1);
        end
        if ((state_q == RUN) && !empty && head_done && head_fault) begin
            state_d = HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            done_q  <= '0;
            state_q <= RUN;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            done_q  <= done_d;
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && enq) begin
            entry_q[tail_idx] <= new_entry;
        end
        if (rstn && wb_hit) begin
            entry_q[wb_idx_i].fault <= entry_q[wb_idx_i].fault | wb_fault_i;
        end
    end

    wb_to_live_entry: assert property (@(posedge clk) disable iff (!rstn) wb_valid_i |-> wb_hit);

endmodule

// File: tb/tb_rob.sv
module tb_rob;
    import rob_pkg::*;

    localparam int N   = 16;
    localparam int IDW = 4;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    di_t            di = '0;
    logic           di_vld = 1'b0;
    logic           di_rdy;
    logic [IDW-1:0] alloc_idx;
    logic           wb_vld = 1'b0;
    logic [IDW-1:0] wb_idx = '0;
    logic           wb_flt = 1'b0;
    rob_entry_t     ret_ent;
    logic           ret_vld;
    logic           flt;
    logic [IDW:0]   cnt;

    always #5 clk = ~clk;

    rob #(.ROBSIZE(N)) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .di_i                 (di),
        .di_i_valid           (di_vld),
        .di_i_ready           (di_rdy),
        .alloc_idx_o          (alloc_idx),
        .wb_valid_i           (wb_vld),
        .wb_idx_i             (wb_idx),
        .wb_fault_i           (wb_flt),
        .retire_entry_o       (ret_ent),
        .retire_entry_o_valid (ret_vld),
        .fault_o              (flt),
        .count_o              (cnt)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference model: an ordered list of in-flight instructions, oldest first.
    typedef struct {
        rob_entry_t e;
        bit         done;
        int         idx;
    } m_ent_t;

    typedef struct {
        int         cyc;
        rob_entry_t e;
    } log_t;

    m_ent_t mq[$];
    log_t   rlog[$];
    int     m_head = 0;
    bit     m_halt = 0;
    bit     started = 0;
    int     cyc = 0;
    bit     m_rdy, m_rv, m_hn;
    m_ent_t m_new;

    function automatic bit exp_rdy();
        return !m_halt && (mq.size() < N);
    endfunction

    function automatic bit exp_rv();
        return !m_halt && (mq.size() > 0) && mq[0].done && !mq[0].e.fault;
    endfunction

    always @(posedge clk) begin
        cyc++;
        started = 1;
        if (!rstn) begin
            mq.delete();
            m_head = 0;
            m_halt = 0;
        end else begin
            m_rdy = exp_rdy();
            m_rv  = exp_rv();
            m_hn  = !m_halt && (mq.size() > 0) && mq[0].done && mq[0].e.fault;
            if (wb_vld) begin
                foreach (mq[i]) begin
                    if (mq[i].idx == int'(wb_idx)) begin
                        mq[i].done    = 1;
                        mq[i].e.fault = mq[i].e.fault | wb_flt;
                    end
                end
            end
            if (m_rv) begin
                void'(mq.pop_front());
                m_head = (m_head + 1) % N;
            end
            if (di_vld && m_rdy) begin
                m_new.e    = '{id: di.id, pc: di.pc, rd: di.rd, prd: di.prd,
                               needprf2arf: di.si.rd_valid, fault: di.fault};
                m_new.done = di.fault;
                m_new.idx  = (m_head + mq.size()) % N;
                mq.push_back(m_new);
            end
            if (m_hn) m_halt = 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("ready", di_rdy, exp_rdy());
            chk("count", cnt, mq.size());
            chk("alloc_idx", alloc_idx, (m_head + mq.size()) % N);
            chk("retire_vld", ret_vld, exp_rv());
            chk("fault", flt, m_halt);
            chk("retire_entry", ret_ent, (mq.size() > 0) ? mq[0].e : '0);
            if (ret_vld) rlog.push_back('{cyc: cyc, e: ret_ent});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        di_vld = 1'b0;
        wb_vld = 1'b0;
        wb_flt = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    function automatic di_t mk(input int n, input int prd, input bit rdv, input bit f);
        di_t d;
        d.id          = 16'(n);
        d.pc          = 32'h1000 + 32'(4 * n);
        d.rd          = 5'(n);
        d.prd         = 6'(prd);
        d.si.rd_valid = rdv;
        d.fault       = f;
        return d;
    endfunction

    int c0, c1, c;
    int sent, wbn, sent_prev, wraps, bad;
    logic [IDW-1:0] prev_alloc;

    initial begin
        // Reset values
        do_reset();
        @(negedge clk);
        chk("rst_ready", di_rdy, 1);
        chk("rst_count", cnt, 0);
        chk("rst_retire_vld", ret_vld, 0);
        chk("rst_fault", flt, 0);
        chk("rst_retire_entry", ret_ent, 0);

        // Out-of-order completion, in-order retire
        do_reset();
        rlog.delete();
        for (int n = 0; n < 3; n++) begin
            di = mk(n, n, 1, 0);
            di_vld = 1'b1;
            tick();
        end
        idle();
        wb_vld = 1'b1;
        wb_idx = 4'd2;
        tick();
        wb_idx = 4'd0;
        c0 = cyc;
        tick();
        wb_idx = 4'd1;
        c1 = cyc;
        tick();
        idle();
        repeat (4) tick();
        chk("ooo_retires", rlog.size(), 3);
        if (rlog.size() == 3) begin
            chk("ooo_prd0", rlog[0].e.prd, 0);
            chk("ooo_prd1", rlog[1].e.prd, 1);
            chk("ooo_prd2", rlog[2].e.prd, 2);
            chk("ooo_cyc0", rlog[0].cyc, c0 + 1);
            chk("ooo_cyc1", rlog[1].cyc, c1 + 1);
            chk("ooo_cyc2", rlog[2].cyc, c1 + 2);
            chk("ooo_pc1", rlog[1].e.pc, 32'h1004);
        end

        // Full ROB: retire does not free space in the same cycle
        do_reset();
        for (int n = 0; n < 16; n++) begin
            di = mk(100 + n, n, 1, 0);
            di_vld = 1'b1;
            tick();
        end
        @(negedge clk);
        chk("full_ready", di_rdy, 0);
        chk("full_count", cnt, 16);
        wb_vld = 1'b1;
        wb_idx = 4'd0;
        c = cyc;
        tick();
        wb_vld = 1'b0;
        @(negedge clk);
        chk("full_ret_cyc", cyc, c + 1);
        chk("full_ret_vld", ret_vld, 1);
        chk("full_ready_during_ret", di_rdy, 0);
        tick();
        di_vld = 1'b0;
        @(negedge clk);
        chk("full_ready_after", di_rdy, 1);
        chk("full_count_after", cnt, 15);
        chk("full_ret_after", ret_vld, 0);

        // Wrap-around streaming at low occupancy
        do_reset();
        rlog.delete();
        sent = 0;
        wbn = 0;
        wraps = 0;
        prev_alloc = '0;
        for (int t = 0; t < 80 && rlog.size() < 40; t++) begin
            sent_prev = sent;
            if (sent < 40 && di_rdy) begin
                di = mk(200 + sent, sent % 64, 1, 0);
                di_vld = 1'b1;
                if (sent > 0 && prev_alloc == 4'd15 && alloc_idx == 4'd0) wraps++;
                prev_alloc = alloc_idx;
                sent++;
            end else begin
                di_vld = 1'b0;
            end
            if (wbn < 40 && (wbn + 3 <= sent_prev || (sent_prev == 40 && wbn < sent_prev))) begin
                wb_vld = 1'b1;
                wb_idx = IDW'(wbn % N);
                wbn++;
            end else begin
                wb_vld = 1'b0;
            end
            tick();
        end
        idle();
        tick();
        chk("wrap_retires", rlog.size(), 40);
        chk("wrap_count", wraps, 2);
        bad = 0;
        for (int i = 1; i < rlog.size(); i++) begin
            if (rlog[i].e.id <= rlog[i-1].e.id) bad++;
        end
        chk("wrap_order", bad, 0);
        if (rlog.size() == 40) begin
            chk("wrap_first_id", rlog[0].e.id, 200);
            chk("wrap_last_id", rlog[39].e.id, 239);
        end

        // No destination register
        do_reset();
        rlog.delete();
        di = mk(300, 5, 0, 0);
        di_vld = 1'b1;
        tick();
        idle();
        wb_vld = 1'b1;
        wb_idx = 4'd0;
        tick();
        idle();
        tick();
        tick();
        chk("nord_retires", rlog.size(), 1);
        if (rlog.size() == 1) begin
            chk("nord_needprf2arf", rlog[0].e.needprf2arf, 0);
            chk("nord_id", rlog[0].e.id, 300);
        end

        // Execution fault halts retirement
        do_reset();
        rlog.delete();
        for (int n = 0; n < 2; n++) begin
            di = mk(500 + n, 10 + n, 1, 0);
            di_vld = 1'b1;
            tick();
        end
        idle();
        wb_vld = 1'b1;
        wb_idx = 4'd0;
        tick();
        wb_idx = 4'd1;
        wb_flt = 1'b1;
        tick();
        idle();
        @(negedge clk);
        chk("flt_before", flt, 0);
        chk("flt_head_no_retire", ret_vld, 0);
        tick();
        @(negedge clk);
        chk("flt_after", flt, 1);
        chk("flt_ready", di_rdy, 0);
        di = mk(600, 20, 1, 0);
        di_vld = 1'b1;
        repeat (5) tick();
        idle();
        @(negedge clk);
        chk("flt_retires", rlog.size(), 1);
        chk("flt_ready_held", di_rdy, 0);
        chk("flt_count_held", cnt, 1);
        do_reset();
        @(negedge clk);
        chk("flt_clear_fault", flt, 0);
        chk("flt_clear_ready", di_rdy, 1);

        // Fault flagged at rename is done on arrival
        rlog.delete();
        di = mk(400, 0, 1, 1);
        di_vld = 1'b1;
        tick();
        idle();
        @(negedge clk);
        chk("dflt_before", flt, 0);
        tick();
        @(negedge clk);
        chk("dflt_after", flt, 1);
        chk("dflt_retires", rlog.size(), 0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
